// File: rtl/qbus_pkg.sv
// qbus_pkg: shared types and constants for the QBus DMA target.
//   - qstate_t : target FSM states
//   - QBUS_*   : central-bus field widths and the default RAM window base
//   - qmax3    : helper used to size the shared delay/timeout counter
package qbus_pkg;

  localparam int QBUS_AW_W = 22;   // address/data field on the bus
  localparam int QBUS_DW   = 16;   // data word width

  localparam logic [QBUS_AW_W-1:0] QBUS_BASE = 22'o00040000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GDLY,
    S_GRANT,
    S_OWN,
    S_ADDR,
    S_DLY,
    S_RPLY,
    S_WEND
  } qstate_t;

  function automatic int qmax3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/qdma_ram.sv
// qdma_ram: 2^AW x 16 word RAM behind the DMA target.
//   i_clk            clock
//   i_we, i_be[1:0]  write strobe and byte enables (be[0]=low byte)
//   i_waddr, i_wdata write word address / data
//   i_re, i_raddr    read strobe / word address
//   o_rdata          read data, valid the clock after i_re; held otherwise
// No reset: contents survive a bus INIT.
module qdma_ram #(
  parameter int AW = 9
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [1:0]    i_be,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata
);

  logic [15:0] r_mem [0:(1<<AW)-1];
  logic [15:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      if (i_be[0]) r_mem[i_waddr][7:0]  <= i_wdata[7:0];
      if (i_be[1]) r_mem[i_waddr][15:8] <= i_wdata[15:8];
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/qbus_dma_target.sv
// qbus_dma_target: central-bus side of the 096 DMA path. Grants nDMR,
// then serves the 096's DATI/DATO/DATOB cycles from a local RAM window.
//   PIN_CLK, PIN_nINIT          clock, synchronous active-low reset
//   PIN_nDMR, PIN_nSACK         DMA request / bus acknowledge from the 096
//   PIN_nDMGO                   DMA grant to the 096
//   PIN_nSYNC/nDIN/nDOUT/nWTBT  bus control strobes
//   PIN_nAD_in                  inverted address/data (22 bits)
//   PIN_nAD_out, PIN_AD_oe      inverted read data and its drive enable
//   PIN_nRPLY                   bus reply
//   tmo_err                     one-clock pulse on SACK timeout
// Build option: define QDMA_SACK_TMO_EN to abandon a grant that is not
// acknowledged within SACK_TMO clocks; otherwise GRANT waits forever.
// Delay timing: GNT_DLY / RPLY_DLY count clocks from the edge at which the
// FSM first acts on the sampled request/strobe to the output edge.
module qbus_dma_target
  import qbus_pkg::*;
#(
  parameter logic [QBUS_AW_W-1:0] BASE = QBUS_BASE,
  parameter int AW       = 9,
  parameter int GNT_DLY  = 2,
  parameter int RPLY_DLY = 4,
  parameter int SACK_TMO = 64
) (
  input  logic                 PIN_CLK,
  input  logic                 PIN_nINIT,
  input  logic                 PIN_nDMR,
  input  logic                 PIN_nSACK,
  output logic                 PIN_nDMGO,
  input  logic                 PIN_nSYNC,
  input  logic                 PIN_nDIN,
  input  logic                 PIN_nDOUT,
  input  logic                 PIN_nWTBT,
  input  logic [QBUS_AW_W-1:0] PIN_nAD_in,
  output logic [QBUS_DW-1:0]   PIN_nAD_out,
  output logic                 PIN_AD_oe,
  output logic                 PIN_nRPLY,
  output logic                 tmo_err
);

  // One counter serves the grant delay, the reply delay and the SACK timeout.
  localparam int CW = $clog2(qmax3(GNT_DLY, RPLY_DLY, SACK_TMO) + 1);

  // Sampled bus inputs
  logic                 r_nDMR, r_nSACK, r_nSYNC, r_nSYNC_d, r_nDIN, r_nDOUT, r_nWTBT;
  logic [QBUS_AW_W-1:0] r_nAD;

  qstate_t              r_state;
  logic [CW-1:0]        r_cnt;
  logic [QBUS_AW_W-1:0] r_addr;
  logic                 r_is_read;
  logic                 r_ndmgo, r_nrply, r_ad_oe, r_tmo;

  logic                 w_hit, w_sync_fall, w_abort, w_act;
  logic [15:0]          w_rdata;
  logic [1:0]           w_be;

  always_ff @(posedge PIN_CLK) begin
    if (!PIN_nINIT) begin
      r_nDMR    <= 1'b1;
      r_nSACK   <= 1'b1;
      r_nSYNC   <= 1'b1;
      r_nSYNC_d <= 1'b1;
      r_nDIN    <= 1'b1;
      r_nDOUT   <= 1'b1;
      r_nWTBT   <= 1'b1;
      r_nAD     <= '1;
    end else begin
      r_nDMR    <= PIN_nDMR;
      r_nSACK   <= PIN_nSACK;
      r_nSYNC   <= PIN_nSYNC;
      r_nSYNC_d <= r_nSYNC;
      r_nDIN    <= PIN_nDIN;
      r_nDOUT   <= PIN_nDOUT;
      r_nWTBT   <= PIN_nWTBT;
      r_nAD     <= PIN_nAD_in;
    end
  end

  assign w_hit       = (r_addr[QBUS_AW_W-1:AW+1] == BASE[QBUS_AW_W-1:AW+1]);
  assign w_sync_fall = r_nSYNC_d && !r_nSYNC;
  // Losing SYNC or the active strobe during the delay cancels the cycle,
  // which also guarantees nRPLY never falls without SYNC.
  assign w_abort     = r_nSYNC || (r_is_read ? r_nDIN : r_nDOUT);
  // Last DLY clock: RAM access happens on the same edge that drops nRPLY.
  assign w_act       = (r_state == S_DLY) && !w_abort && (r_cnt <= CW'(1));
  assign w_be        = r_nWTBT ? 2'b11 : (r_addr[0] ? 2'b10 : 2'b01);

  always_ff @(posedge PIN_CLK) begin
    if (!PIN_nINIT) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_is_read <= 1'b0;
      r_ndmgo   <= 1'b1;
      r_nrply   <= 1'b1;
      r_ad_oe   <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_tmo <= 1'b0;
      case (r_state)
        S_IDLE: if (!r_nDMR) begin
          r_cnt   <= CW'(GNT_DLY);
          r_state <= S_GDLY;
        end
        S_GDLY: begin
          if (r_nDMR) r_state <= S_IDLE;
          else if (r_cnt <= CW'(1)) begin
            r_ndmgo <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_GRANT;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_GRANT: begin
          if (!r_nSACK) begin
            r_ndmgo <= 1'b1;
            r_state <= S_OWN;
          end
`ifdef QDMA_SACK_TMO_EN
          else if (r_cnt == CW'(SACK_TMO - 1)) begin
            r_ndmgo <= 1'b1;
            r_tmo   <= 1'b1;
            r_state <= S_IDLE;
          end else r_cnt <= r_cnt + 1'b1;
`endif
        end
        S_OWN: begin
          if (w_sync_fall) begin
            r_addr  <= ~r_nAD;
            r_state <= S_ADDR;
          end else if (r_nSACK && r_nSYNC) r_state <= S_IDLE;
        end
        S_ADDR: begin
          // A miss just sits here until the master gives up.
          if (r_nSYNC) r_state <= S_OWN;
          else if (w_hit && (!r_nDIN || !r_nDOUT)) begin
            r_is_read <= !r_nDIN;
            r_cnt     <= CW'(RPLY_DLY);
            r_state   <= S_DLY;
          end
        end
        S_DLY: begin
          if (w_abort) r_state <= S_WEND;
          else if (r_cnt <= CW'(1)) begin
            r_ad_oe <= r_is_read;
            r_nrply <= 1'b0;
            r_state <= S_RPLY;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_RPLY: if ((r_nDIN && r_nDOUT) || r_nSYNC) begin
          r_nrply <= 1'b1;
          r_ad_oe <= 1'b0;
          r_state <= S_WEND;
        end
        S_WEND: if (r_nSYNC) r_state <= S_OWN;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  qdma_ram #(.AW(AW)) u_ram (
    .i_clk   (PIN_CLK),
    .i_we    (w_act && !r_is_read),
    .i_be    (w_be),
    .i_waddr (r_addr[AW:1]),
    .i_wdata (~r_nAD[15:0]),
    .i_re    (w_act && r_is_read),
    .i_raddr (r_addr[AW:1]),
    .o_rdata (w_rdata)
  );

  // RAM output register and r_ad_oe update on the same edge.
  assign PIN_nAD_out = r_ad_oe ? ~w_rdata : 16'hFFFF;
  assign PIN_AD_oe   = r_ad_oe;
  assign PIN_nRPLY   = r_nrply;
  assign PIN_nDMGO   = r_ndmgo;
`ifdef QDMA_SACK_TMO_EN
  assign tmo_err     = r_tmo;
`else
  assign tmo_err     = 1'b0;
`endif

endmodule

// File: tb/tb_qbus_dma_target.sv
module tb_qbus_dma_target;

  localparam logic [21:0] BASE = 22'o00040000;
  localparam int AW = 9, GNT_DLY = 2, RPLY_DLY = 4, SACK_TMO = 64;

  logic        clk = 1'b0;
  logic        ninit, ndmr, nsack, nsync, ndin, ndout, nwtbt;
  logic [21:0] nad;
  logic        ndmgo, ad_oe, nrply, tmo;
  logic [15:0] nad_out;

  qbus_dma_target #(.BASE(BASE), .AW(AW), .GNT_DLY(GNT_DLY),
                    .RPLY_DLY(RPLY_DLY), .SACK_TMO(SACK_TMO)) dut (
    .PIN_CLK(clk), .PIN_nINIT(ninit), .PIN_nDMR(ndmr), .PIN_nSACK(nsack),
    .PIN_nDMGO(ndmgo), .PIN_nSYNC(nsync), .PIN_nDIN(ndin), .PIN_nDOUT(ndout),
    .PIN_nWTBT(nwtbt), .PIN_nAD_in(nad), .PIN_nAD_out(nad_out),
    .PIN_AD_oe(ad_oe), .PIN_nRPLY(nrply), .tmo_err(tmo));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, n_falls = 0;
  bit chk_on = 0, prev_rply = 1;

  // expected outputs, moved by the stimulus at the edge they must change on
  logic        e_dmgo = 1, e_rply = 1, e_oe = 0, e_tmo = 0;
  logic [15:0] e_data = 0;
  logic [15:0] mem [0:(1<<AW)-1];   // reference RAM, indexed by word

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("nDMGO", {31'd0, ndmgo}, {31'd0, e_dmgo});
      chk("nRPLY", {31'd0, nrply}, {31'd0, e_rply});
      chk("AD_oe", {31'd0, ad_oe}, {31'd0, e_oe});
      chk("nAD_out", {16'd0, nad_out}, {16'd0, (e_oe ? ~e_data : 16'hFFFF)});
      chk("tmo_err", {31'd0, tmo}, {31'd0, e_tmo});
      if (prev_rply && !nrply) n_falls++;
      prev_rply = nrply;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // request: grant appears GNT_DLY clocks after the FSM sees the sampled request
  task automatic req();
    ndmr = 0;
    repeat (GNT_DLY + 1) tick();
    tick(); e_dmgo = 0;
  endtask

  task automatic ack();
    nsack = 0; ndmr = 1;
    tick();
    tick(); e_dmgo = 1;
  endtask

  // One DATI/DATO/DATOB. Returns the (non-inverted) read data seen at reply.
  task automatic cyc(input logic [21:0] a, input bit rd, input bit byt,
                     input logic [15:0] d, output logic [15:0] cap);
    int unsigned ia, wi;
    bit hit;
    ia  = a;
    hit = (ia >= BASE) && (ia < BASE + (2 << AW));
    wi  = (ia - BASE) / 2;
    cap = 16'hxxxx;
    nsync = 0; nad = ~a;
    tick(); tick();
    if (rd) begin ndin = 0; nad = '1; end
    else begin ndout = 0; nwtbt = !byt; nad = ~{6'd0, d}; end
    repeat (RPLY_DLY + 1) tick();
    tick();
    if (hit) begin
      e_rply = 0;
      if (rd) begin e_oe = 1; e_data = mem[wi]; cap = ~nad_out; end
      else if (!byt) mem[wi] = d;
      else if (ia % 2 == 1) mem[wi][15:8] = d[15:8];
      else mem[wi][7:0] = d[7:0];
    end else repeat (200) tick();
    ndin = 1; ndout = 1; nwtbt = 1;
    tick();
    tick(); e_rply = 1; e_oe = 0;
    nsync = 1; nad = '1;
    tick(); tick();
  endtask

  logic [15:0] rd;
  int f0;

  initial begin
    ninit = 0; ndmr = 1; nsack = 1; nsync = 1; ndin = 1; ndout = 1; nwtbt = 1; nad = '1;
    tick(); chk_on = 1;
    tick(); tick();
    ninit = 1;
    tick(); tick();

    // word write then read
    req(); ack();
    cyc(22'o40200, 0, 0, 16'o054321, rd);
    cyc(22'o40200, 1, 0, 16'd0, rd);
    chk("rd_word", {16'd0, rd}, {16'd0, 16'o054321});

    // byte writes, low lane then high lane
    cyc(22'o40400, 0, 1, 16'o000222, rd);
    cyc(22'o40401, 0, 1, 16'o111000, rd);
    cyc(22'o40400, 1, 0, 16'd0, rd);
    chk("rd_bytes", {16'd0, rd}, {16'd0, 16'o111222});

    // miss: never replies, then a hit still works under the same SACK
    f0 = n_falls;
    cyc(22'o17772140, 1, 0, 16'd0, rd);
    chk("miss_no_rply", n_falls - f0, 0);
    cyc(22'o40400, 1, 0, 16'd0, rd);
    chk("rd_after_miss", {16'd0, rd}, {16'd0, 16'o111222});
    nsack = 1;
    repeat (3) tick();

    // three writes under one SACK; the re-grant proves IDLE was reached
    f0 = n_falls;
    req(); ack();
    cyc(22'o40002, 0, 0, 16'o000001, rd);
    cyc(22'o40004, 0, 0, 16'o177777, rd);
    cyc(22'o40006, 0, 0, 16'o125252, rd);
    chk("multi_rply_cnt", n_falls - f0, 3);
    nsack = 1;
    repeat (3) tick();
    req(); ack();
    cyc(22'o40004, 1, 0, 16'd0, rd);
    chk("rd_multi", {16'd0, rd}, {16'd0, 16'o177777});
    nsack = 1;
    repeat (3) tick();

`ifdef QDMA_SACK_TMO_EN
    // grant abandoned SACK_TMO clocks after it is issued
    req();
    ndmr = 1;
    repeat (SACK_TMO - 1) tick();
    tick(); e_dmgo = 1; e_tmo = 1;
    tick(); e_tmo = 0;
    repeat (5) tick();
`else
    // grant held indefinitely
    req();
    ndmr = 1;
    repeat (100) tick();
    ack();
    nsack = 1;
    repeat (3) tick();
`endif

    // reset while a read reply is being driven
    req(); ack();
    nsync = 0; nad = ~22'o40200;
    tick(); tick();
    ndin = 0; nad = '1;
    repeat (RPLY_DLY + 1) tick();
    tick(); e_rply = 0; e_oe = 1; e_data = mem[(22'o40200 - BASE) / 2];
    tick();
    ninit = 0;
    tick(); e_rply = 1; e_oe = 0; e_dmgo = 1;
    ndin = 1; nsync = 1; nsack = 1; ndmr = 1;
    tick(); tick();
    ninit = 1;
    tick(); tick();
    req(); ack();
    cyc(22'o40200, 1, 0, 16'd0, rd);
    chk("rd_after_init", {16'd0, rd}, {16'd0, 16'o054321});
    nsack = 1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
